wb_cmd_regs: RTL and testbench

WB_CMD_REGS -- requirements
Module: wb_cmd_regs

---
 rtl/wb_cmd_pkg.sv | 48 ++++
 rtl/wb_cmd_regs_if.sv | 23 ++
 rtl/wb_cmd_fsm.sv | 99 +++++++++
 rtl/wb_cmd_regs.sv | 127 ++++++++++++
 tb/tb_wb_cmd_regs.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_cmd_pkg.sv
// rtl/wb_cmd_pkg.sv - shared constants and enums for the Wishbone command register block
package wb_cmd_pkg;

    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;
    localparam logic [1:0] ADR_FSMR = 2'd3;

    localparam int CSR_E_BIT    = 7;
    localparam int CSR_IE_BIT   = 6;
    localparam int CSR_BB_BIT   = 5;
    localparam int CSR_BC_BIT   = 4;

    localparam int CMDR_DON_BIT = 7;
    localparam int CMDR_NAK_BIT = 6;
    localparam int CMDR_AL_BIT  = 5;
    localparam int CMDR_ERR_BIT = 4;

    typedef enum logic [2:0] {
        CMD_WAIT     = 3'd0,
        CMD_WRITE    = 3'd1,
        CMD_READ_ACK = 3'd2,
        CMD_READ_NAK = 3'd3,
        CMD_START    = 3'd4,
        CMD_STOP     = 3'd5,
        CMD_SET_BUS  = 3'd6,
        CMD_INVALID  = 3'd7
    } cmd_code_e;

    typedef enum logic [1:0] {
        RSP_DON = 2'd0,
        RSP_NAK = 2'd1,
        RSP_AL  = 2'd2,
        RSP_ERR = 2'd3
    } rsp_status_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } fsm_state_e;

    // Status is stored indexed by response code; CMDR shows DON in the MSB.
    function automatic logic [7:0] cmdr_value(input logic [3:0] sts, input logic [2:0] code);
        return {sts[RSP_DON], sts[RSP_NAK], sts[RSP_AL], sts[RSP_ERR], 1'b0, code};
    endfunction

endpackage

// File: rtl/wb_cmd_regs_if.sv
// rtl/wb_cmd_regs_if.sv - Wishbone slave bus bundle for the command register block
interface wb_cmd_regs_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i,
        output dat_o, ack_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i,
        input  dat_o, ack_o
    );
endinterface

// File: rtl/wb_cmd_fsm.sv
// rtl/wb_cmd_fsm.sv - command issue / response state machine with CMDR code and status bits
module wb_cmd_fsm
    import wb_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       cmdr_wr_i,
    input  logic [2:0] cmdr_code_i,
    input  logic [7:0] dpr_i,
    input  logic       cmd_ready_i,
    input  logic       rsp_valid_i,
    input  logic [1:0] rsp_status_i,
    output logic       cmd_valid_o,
    output logic [2:0] cmd_code_o,
    output logic [7:0] cmd_data_o,
    output logic [3:0] status_o,
    output logic       sts_set_o,
    output logic       cmd_accept_o,
    output logic       ld_bus_id_o,
    output logic       ld_dpr_o
);

    fsm_state_e state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [7:0] data_q, data_d;
    logic [3:0] sts_q, sts_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            data_q  <= '0;
            sts_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            data_q  <= data_d;
            sts_q   <= sts_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        data_d       = data_q;
        sts_d        = sts_q;
        sts_set_o    = 1'b0;
        cmd_accept_o = 1'b0;
        ld_bus_id_o  = 1'b0;
        ld_dpr_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmdr_wr_i && en_i) begin
                    cmd_accept_o = 1'b1;
                    code_d       = cmdr_code_i;
                    sts_d        = '0;
                    if (cmdr_code_i == CMD_INVALID) begin
                        sts_d[RSP_ERR] = 1'b1;
                        sts_set_o      = 1'b1;
                    end else begin
                        // Snapshot DPR so the byte stays stable while the handshake is pending.
                        data_d  = dpr_i;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    sts_d   = '0;
                end else if (cmd_ready_i) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    sts_d   = '0;
                end else if (rsp_valid_i) begin
                    sts_d[rsp_status_i] = 1'b1;
                    sts_set_o           = 1'b1;
                    state_d             = ST_IDLE;
                    if (rsp_status_i == RSP_DON) begin
                        ld_bus_id_o = (code_q == CMD_SET_BUS);
                        ld_dpr_o    = (code_q == CMD_READ_ACK) || (code_q == CMD_READ_NAK);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_valid_o = (state_q == ST_ISSUE);
    assign cmd_code_o  = code_q;
    assign cmd_data_o  = data_q;
    assign status_o    = sts_q;

endmodule

// File: rtl/wb_cmd_regs.sv
// rtl/wb_cmd_regs.sv - Wishbone register file (CSR/DPR/CMDR/FSMR) driving a byte-level command FSM
module wb_cmd_regs
    import wb_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_cmd_regs_if.slave wb,
    output logic         cmd_valid_o,
    output logic [2:0]   cmd_code_o,
    output logic [7:0]   cmd_data_o,
    input  logic         cmd_ready_i,
    input  logic         rsp_valid_i,
    input  logic [1:0]   rsp_status_i,
    input  logic [7:0]   rsp_data_i,
    input  logic         bb_i,
    input  logic         bc_i,
    input  logic [7:0]   fsm_state_i,
    output logic         irq_o
);

    logic       ack_q, ack_d;
    logic       e_q, e_d;
    logic       ie_q, ie_d;
    logic [3:0] bus_id_q, bus_id_d;
    logic [7:0] dpr_q, dpr_d;
    logic       pend_q, pend_d;
    logic       irq_q, irq_d;

    logic       wr_en, rd_en;
    logic       sel_csr, sel_dpr, sel_cmdr;
    logic [7:0] wdata, rdata;
    logic [3:0] status;
    logic       sts_set, cmd_accept, ld_bus_id, ld_dpr;

    // A fresh request is acked once; ack_q low in between enforces the idle cycle.
    assign ack_d = wb.cyc_i & wb.stb_i & ~ack_q;
    assign wr_en = ack_q & wb.cyc_i & wb.stb_i & wb.we_i;
    assign rd_en = ack_q & wb.cyc_i & wb.stb_i & ~wb.we_i;
    assign wdata = wb.dat_i[7:0];

    assign sel_csr  = (wb.adr_i == ADDR_WIDTH'(ADR_CSR));
    assign sel_dpr  = (wb.adr_i == ADDR_WIDTH'(ADR_DPR));
    assign sel_cmdr = (wb.adr_i == ADDR_WIDTH'(ADR_CMDR));

    wb_cmd_fsm u_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (e_q),
        .cmdr_wr_i    (wr_en & sel_cmdr),
        .cmdr_code_i  (wdata[2:0]),
        .dpr_i        (dpr_q),
        .cmd_ready_i  (cmd_ready_i),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_status_i (rsp_status_i),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_code_o   (cmd_code_o),
        .cmd_data_o   (cmd_data_o),
        .status_o     (status),
        .sts_set_o    (sts_set),
        .cmd_accept_o (cmd_accept),
        .ld_bus_id_o  (ld_bus_id),
        .ld_dpr_o     (ld_dpr)
    );

    always_comb begin
        e_d      = e_q;
        ie_d     = ie_q;
        bus_id_d = ld_bus_id ? dpr_q[3:0] : bus_id_q;
        dpr_d    = ld_dpr ? rsp_data_i : dpr_q;
        pend_d   = pend_q;
        if (wr_en && sel_csr) begin
            e_d  = wdata[CSR_E_BIT];
            ie_d = wdata[CSR_IE_BIT];
        end
        if (wr_en && sel_dpr) begin
            dpr_d = wdata;
        end
        if ((rd_en && sel_cmdr) || cmd_accept) begin
            pend_d = 1'b0;
        end
        if (sts_set && ie_q) begin
            pend_d = 1'b1;
        end
        irq_d = pend_d & e_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            e_q      <= 1'b0;
            ie_q     <= 1'b0;
            bus_id_q <= '0;
            dpr_q    <= '0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            e_q      <= e_d;
            ie_q     <= ie_d;
            bus_id_q <= bus_id_d;
            dpr_q    <= dpr_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_csr) begin
            rdata = {e_q, ie_q, bb_i, bc_i, bus_id_q};
        end else if (sel_dpr) begin
            rdata = dpr_q;
        end else if (sel_cmdr) begin
            rdata = cmdr_value(status, cmd_code_o);
        end else if (wb.adr_i == ADDR_WIDTH'(ADR_FSMR)) begin
            rdata = fsm_state_i;
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.dat_o = (ack_q & ~wb.we_i) ? DATA_WIDTH'(rdata) : '0;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_cmd_regs.sv
// tb/tb_wb_cmd_regs.sv - directed self-checking bench for wb_cmd_regs
module tb_wb_cmd_regs;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic [7:0] rsp_data;
    logic       bb, bc;
    logic [7:0] fsm_state;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    wb_cmd_regs_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

    wb_cmd_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wb           (bus),
        .cmd_valid_o  (cmd_valid),
        .cmd_code_o   (cmd_code),
        .cmd_data_o   (cmd_data),
        .cmd_ready_i  (cmd_ready),
        .rsp_valid_i  (rsp_valid),
        .rsp_status_i (rsp_status),
        .rsp_data_i   (rsp_data),
        .bb_i         (bb),
        .bc_i         (bc),
        .fsm_state_i  (fsm_state),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic wr, input logic [1:0] a, input logic [7:0] d,
                             input logic [7:0] exp, input string tag);
        @(negedge clk);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = wr;
        bus.adr_i = a;
        bus.dat_i = d;
        tick();
        check({tag, "/ack"}, 8'(bus.ack_o), 8'h01);
        if (!wr) check({tag, "/dat"}, bus.dat_o, exp);
        tick();
        check({tag, "/ack_low"}, 8'(bus.ack_o), 8'h00);
        check({tag, "/dat_idle"}, bus.dat_o, 8'h00);
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [7:0] d, input string tag);
        wb_access(1'b1, a, d, 8'h00, tag);
    endtask

    task automatic wb_read(input logic [1:0] a, input logic [7:0] exp, input string tag);
        wb_access(1'b0, a, 8'h00, exp, tag);
    endtask

    // Called right after the CMDR write completes: valid must hold for n_late cycles without ready.
    task automatic issue(input int n_late, input logic [2:0] code, input logic [7:0] data,
                         input string tag);
        for (int i = 0; i < n_late; i++) begin
            check({tag, "/valid_wait"}, 8'(cmd_valid), 8'h01);
            check({tag, "/code"}, 8'(cmd_code), 8'(code));
            check({tag, "/data"}, cmd_data, data);
            tick();
        end
        check({tag, "/valid_rdy"}, 8'(cmd_valid), 8'h01);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check({tag, "/valid_done"}, 8'(cmd_valid), 8'h00);
    endtask

    task automatic respond(input logic [1:0] st, input logic [7:0] d);
        rsp_valid  = 1'b1;
        rsp_status = st;
        rsp_data   = d;
        tick();
        rsp_valid  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.cyc_i  = 1'b0;
        bus.stb_i  = 1'b0;
        bus.we_i   = 1'b0;
        bus.adr_i  = 2'd0;
        bus.dat_i  = 8'h00;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_status = 2'd0;
        rsp_data   = 8'h00;
        bb         = 1'b1;
        bc         = 1'b0;
        fsm_state  = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        check("rst/ack", 8'(bus.ack_o), 8'h00);
        check("rst/dat", bus.dat_o, 8'h00);
        check("rst/valid", 8'(cmd_valid), 8'h00);
        check("rst/code", 8'(cmd_code), 8'h00);
        check("rst/cdata", cmd_data, 8'h00);
        check("rst/irq", 8'(irq), 8'h00);
        @(negedge clk);
        rst = 1'b0;

        wb_read(2'd0, 8'h20, "rd_csr");
        wb_read(2'd1, 8'h00, "rd_dpr");
        wb_read(2'd2, 8'h00, "rd_cmdr");
        wb_read(2'd3, 8'h3C, "rd_fsmr");

        // Strobe held: ack pulses 1,0,1
        @(negedge clk);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.adr_i = 2'd3;
        tick();
        check("hold/ack1", 8'(bus.ack_o), 8'h01);
        tick();
        check("hold/gap", 8'(bus.ack_o), 8'h00);
        tick();
        check("hold/ack2", 8'(bus.ack_o), 8'h01);
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        tick();

        // SET_BUS with late ready
        wb_write(2'd0, 8'hC0, "w_csr");
        wb_write(2'd1, 8'h05, "w_dpr");
        wb_write(2'd2, 8'h06, "w_setbus");
        issue(3, 3'd6, 8'h05, "setbus");
        respond(2'd0, 8'h00);
        check("setbus/irq", 8'(irq), 8'h01);
        wb_read(2'd0, 8'hE5, "setbus_csr");
        wb_read(2'd2, 8'h86, "setbus_cmdr");
        check("setbus/irq_clr", 8'(irq), 8'h00);

        // READ_ACK loads DPR from response
        wb_write(2'd2, 8'h02, "w_rdack");
        issue(0, 3'd2, 8'h05, "rdack");
        respond(2'd0, 8'hA5);
        wb_read(2'd1, 8'hA5, "rdack_dpr");
        wb_read(2'd2, 8'h82, "rdack_cmdr");

        // START, then CMDR write while BUSY is ignored
        wb_write(2'd2, 8'h04, "w_start");
        issue(1, 3'd4, 8'hA5, "start");
        wb_write(2'd2, 8'h05, "w_stop_busy");
        check("busy_wr/valid", 8'(cmd_valid), 8'h00);
        check("busy_wr/code", 8'(cmd_code), 8'h04);
        respond(2'd2, 8'h00);
        wb_read(2'd2, 8'h24, "start_cmdr");

        // Invalid code with IE=0
        wb_write(2'd0, 8'h80, "w_csr_noie");
        wb_write(2'd2, 8'h07, "w_inval");
        check("inval/valid", 8'(cmd_valid), 8'h00);
        tick();
        check("inval/valid2", 8'(cmd_valid), 8'h00);
        check("inval/irq", 8'(irq), 8'h00);
        wb_read(2'd2, 8'h17, "inval_cmdr");

        // Disable during BUSY, late response ignored
        wb_write(2'd0, 8'hC0, "w_csr_en");
        wb_write(2'd2, 8'h01, "w_write");
        issue(0, 3'd1, 8'hA5, "write");
        wb_write(2'd0, 8'h00, "w_csr_off");
        tick();
        check("abort_busy/valid", 8'(cmd_valid), 8'h00);
        respond(2'd0, 8'h00);
        check("abort_busy/irq", 8'(irq), 8'h00);
        wb_read(2'd2, 8'h01, "abort_busy_cmdr");

        // Disable during ISSUE drops valid
        wb_write(2'd0, 8'hC0, "w_csr_en2");
        wb_write(2'd2, 8'h03, "w_rdnak");
        check("abort_issue/valid_on", 8'(cmd_valid), 8'h01);
        wb_write(2'd0, 8'h00, "w_csr_off2");
        tick();
        check("abort_issue/valid_off", 8'(cmd_valid), 8'h00);
        wb_read(2'd2, 8'h03, "abort_issue_cmdr");

        // Asynchronous reset mid-command
        wb_write(2'd0, 8'hC0, "w_csr_en3");
        wb_write(2'd2, 8'h06, "w_setbus2");
        check("arst/valid_pre", 8'(cmd_valid), 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("arst/valid", 8'(cmd_valid), 8'h00);
        check("arst/code", 8'(cmd_code), 8'h00);
        check("arst/cdata", cmd_data, 8'h00);
        check("arst/irq", 8'(irq), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        bb  = 1'b0;
        bc  = 1'b1;
        wb_read(2'd0, 8'h10, "arst_csr");
        wb_read(2'd1, 8'h00, "arst_dpr");
        wb_read(2'd2, 8'h00, "arst_cmdr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
